// File: rtl/wide_fifo_axis_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wide_fifo_axis_reader_pkg
// Brief    : Shared sideband bit positions and state encodings for the wide
//            FIFO writer/reader pair.
// Revision : 1.0 - initial release
// ============================================================================
package wide_fifo_axis_reader_pkg;

  // Sideband (FIFO_DOP) field positions, shared with the upstream writer
  localparam int IDX_LSB  = 0;
  localparam int IDX_W    = 6;
  localparam int LAST_BIT = 6;
  localparam int DROP_BIT = 7;
  localparam int USER_LSB = 8;

  // Packet-level read state
  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_PASS  = 2'd1,
    ST_DROP  = 2'd2
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/wide_fifo_axis_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : wide_fifo_axis_reader_if
// Brief    : FWFT FIFO read port plus AXI4-Stream master bundle.
//            master = the reader block, slave = FIFO/sink environment.
// Revision : 1.0 - initial release
// ============================================================================
interface wide_fifo_axis_reader_if #(
  parameter int C_NUMBER_FIFOS = 4,
  parameter int C_TUSER_WIDTH  = 8 * C_NUMBER_FIFOS - 8
);
  localparam int C_DW = 64 * C_NUMBER_FIFOS;
  localparam int C_KW = 8 * C_NUMBER_FIFOS;

  logic [C_DW-1:0]          fifo_do;
  logic [C_KW-1:0]          fifo_dop;
  logic                     fifo_empty;
  logic                     fifo_rden;
  logic [C_DW-1:0]          m_axis_tdata;
  logic [C_KW-1:0]          m_axis_tkeep;
  logic [C_TUSER_WIDTH-1:0] m_axis_tuser;
  logic                     m_axis_tlast;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;

  modport master (
    input  fifo_do, fifo_dop, fifo_empty,
    output fifo_rden,
    output m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    output fifo_do, fifo_dop, fifo_empty,
    input  fifo_rden,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready
  );

endinterface
`default_nettype wire

// File: rtl/wide_fifo_axis_reader_axis_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : axis_skid_buffer
// Brief    : 2-entry in-order buffer with registered output valid. Slot 0 is
//            always the presented word; slot 1 holds the overflow word.
// Revision : 1.0 - initial release
// ============================================================================
module axis_skid_buffer #(
  parameter int C_WIDTH = 8
) (
  input  wire                clk,
  input  wire                rst_n,
  input  wire                i_in_valid,
  output logic               o_in_ready,
  input  wire  [C_WIDTH-1:0] i_in_data,
  output logic               o_out_valid,
  input  wire                i_out_ready,
  output logic [C_WIDTH-1:0] o_out_data,
  output logic [1:0]         o_occ
);

  logic [C_WIDTH-1:0] r_slot0;
  logic [C_WIDTH-1:0] r_slot1;
  logic [1:0]         r_occ;
  logic               r_valid;
  logic               w_push;
  logic               w_pop;

  // Ready depends only on registered occupancy, never on the downstream ready
  assign o_in_ready  = (r_occ != 2'd2);
  assign w_push      = i_in_valid & o_in_ready;
  assign w_pop       = r_valid & i_out_ready;
  assign o_out_valid = r_valid;
  assign o_out_data  = r_slot0;
  assign o_occ       = r_occ;

  // Occupancy-driven slot update; simultaneous push/pop keeps the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_occ   <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_occ)
        2'd0: begin
          if (w_push) begin
            r_slot0 <= i_in_data;
            r_occ   <= 2'd1;
            r_valid <= 1'b1;
          end
        end
        2'd1: begin
          case ({w_push, w_pop})
            2'b11: r_slot0 <= i_in_data;
            2'b10: begin
              r_slot1 <= i_in_data;
              r_occ   <= 2'd2;
            end
            2'b01: begin
              r_occ   <= 2'd0;
              r_valid <= 1'b0;
            end
            default: ;
          endcase
        end
        2'd2: begin
          if (w_pop) begin
            r_slot0 <= r_slot1;
            r_occ   <= 2'd1;
          end
        end
        default: begin
          r_occ   <= 2'd0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wide_fifo_axis_reader.sv
`default_nettype none
// ============================================================================
// Module   : wide_fifo_axis_reader
// Brief    : Drains an FWFT wide FIFO onto an AXI4-Stream master. Decodes the
//            per-word sideband, discards flagged packets and keeps packet,
//            drop and malformed-word statistics.
// Revision : 1.0 - initial release
// ============================================================================
module wide_fifo_axis_reader
  import wide_fifo_axis_reader_pkg::*;
#(
  parameter int C_NUMBER_FIFOS = 4,
  parameter int C_TUSER_WIDTH  = 8 * C_NUMBER_FIFOS - 8,
  parameter int C_COUNT_WIDTH  = 32
) (
  input  wire                      clk,
  input  wire                      rst_n,
  wide_fifo_axis_reader_if.master  bus,
  output logic [C_COUNT_WIDTH-1:0] o_pkt_count,
  output logic [C_COUNT_WIDTH-1:0] o_drop_count,
  output logic [C_COUNT_WIDTH-1:0] o_err_count
);

  localparam int         C_DW        = 64 * C_NUMBER_FIFOS;
  localparam int         C_KW        = 8 * C_NUMBER_FIFOS;
  localparam int         C_PW        = C_TUSER_WIDTH + 1 + C_KW + C_DW;
  localparam logic [6:0] C_KW7       = 7'(C_KW);
  localparam logic [6:0] C_LAST_IDX7 = 7'(C_KW - 1);
  localparam logic [5:0] C_LAST_IDX6 = 6'(C_KW - 1);

  rd_state_t                r_state;
  logic [C_COUNT_WIDTH-1:0] r_pkt_count;
  logic [C_COUNT_WIDTH-1:0] r_drop_count;
  logic [C_COUNT_WIDTH-1:0] r_err_count;

  logic [IDX_W-1:0]         w_idx;
  logic [6:0]               w_idx_ext;
  logic                     w_idx_big;
  logic [5:0]               w_idx_clamp;
  logic                     w_last;
  logic                     w_drop;
  logic [C_TUSER_WIDTH-1:0] w_user;
  logic [C_KW-1:0]          w_keep;
  logic                     w_malformed;
  logic                     w_head_drop;
  logic                     w_rden;
  logic                     w_fwd;
  logic                     w_push;
  logic                     w_in_ready;
  logic                     w_out_valid;
  logic [C_PW-1:0]          w_out_data;
  logic [1:0]               w_occ;
  logic                     w_beat_last;

  // ---- Head-word sideband decode ----
  assign w_idx     = bus.fifo_dop[IDX_LSB +: IDX_W];
  assign w_last    = bus.fifo_dop[LAST_BIT];
  assign w_drop    = bus.fifo_dop[DROP_BIT];
  assign w_user    = bus.fifo_dop[USER_LSB +: C_TUSER_WIDTH];
  assign w_idx_ext = {1'b0, w_idx};
  assign w_idx_big = (w_idx_ext >= C_KW7);

  // Out-of-range end index is clamped to the top byte and flagged malformed
  assign w_idx_clamp = w_idx_big ? C_LAST_IDX6 : w_idx;
  assign w_malformed = w_last ? w_idx_big : (w_idx_ext != C_LAST_IDX7);

  // Byte enables: bits 0..index on the last word, all ones otherwise
  for (genvar gi = 0; gi < C_KW; gi++) begin : g_keep
    assign w_keep[gi] = ~w_last | (7'(gi) <= {1'b0, w_idx_clamp});
  end

  // Drop flag only matters on a packet's first word; DROP swallows the rest
  assign w_head_drop = (r_state == ST_DROP) || ((r_state == ST_FIRST) && w_drop);

  // Discarded words bypass the buffer, so they are popped even when it is full
  assign w_rden = rst_n & ~bus.fifo_empty & ((w_occ != 2'd2) | w_head_drop);
  assign w_fwd  = w_rden & ~w_head_drop;
  assign w_push = w_fwd & w_in_ready;

  assign bus.fifo_rden = w_rden;

  axis_skid_buffer #(
    .C_WIDTH (C_PW)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (w_push),
    .o_in_ready  (w_in_ready),
    .i_in_data   ({w_user, w_last, w_keep, bus.fifo_do}),
    .o_out_valid (w_out_valid),
    .i_out_ready (bus.m_axis_tready),
    .o_out_data  (w_out_data),
    .o_occ       (w_occ)
  );

  assign {bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata} = w_out_data;
  assign bus.m_axis_tvalid = w_out_valid;
  assign w_beat_last       = w_out_valid & bus.m_axis_tready & w_out_data[C_DW + C_KW];

  // Packet state machine; single-word discarded packets count as drops too
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_FIRST;
      r_drop_count <= '0;
    end else if (w_rden) begin
      case (r_state)
        ST_FIRST: begin
          if (w_drop) begin
            if (w_last) r_drop_count <= r_drop_count + 1'b1;
            else        r_state      <= ST_DROP;
          end else if (!w_last) begin
            r_state <= ST_PASS;
          end
        end
        ST_PASS: begin
          if (w_last) r_state <= ST_FIRST;
        end
        ST_DROP: begin
          if (w_last) begin
            r_state      <= ST_FIRST;
            r_drop_count <= r_drop_count + 1'b1;
          end
        end
        default: r_state <= ST_FIRST;
      endcase
    end
  end

  // Malformed words are counted as they are forwarded into the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_err_count <= '0;
    else if (w_push && w_malformed) r_err_count <= r_err_count + 1'b1;
  end

  // Forwarded packets are counted on the accepted last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_pkt_count <= '0;
    else if (w_beat_last) r_pkt_count <= r_pkt_count + 1'b1;
  end

  assign o_pkt_count  = r_pkt_count;
  assign o_drop_count = r_drop_count;
  assign o_err_count  = r_err_count;

endmodule
`default_nettype wire
